// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with a 2-entry skid buffer, flush and stall.
// Define PIPE_STAGE_STATS_EN to add saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int CTRL_W      = 12,
  parameter int DATA_W      = 32,
  parameter int N_LANES     = 4,
  parameter int TAG_W       = 15,
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic                      clkIn,
  input  logic                      resetIn,
  input  logic                      flushIn,
  input  logic                      stallIn,
  input  logic                      validIn,
  output logic                      readyOut,
  input  logic [CTRL_W-1:0]         ctrlIn,
  input  logic [N_LANES*DATA_W-1:0] dataIn,
  input  logic [TAG_W-1:0]          tagIn,
  output logic                      validOut,
  input  logic                      readyIn,
`ifdef PIPE_STAGE_STATS_EN
  output logic [15:0]               stallCntOut,
  output logic [15:0]               bubbleCntOut,
`endif
  output logic [CTRL_W-1:0]         ctrlOut,
  output logic [N_LANES*DATA_W-1:0] dataOut,
  output logic [TAG_W-1:0]          tagOut
);
  localparam int PW = CTRL_W + N_LANES*DATA_W + TAG_W;
  // state encoding doubles as {skidValid, mainValid}
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b11} state_e;
  state_e        state_q, state_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_w;
  logic          acc, dlv;
  assign in_w     = {ctrlIn, dataIn, tagIn};
  assign readyOut = ~state_q[1];
  assign validOut = state_q[0];
  assign acc      = validIn & readyOut & ~stallIn & ~flushIn;
  assign dlv      = validOut & readyIn & ~stallIn & ~flushIn;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flushIn) begin
      state_d = EMPTY;
      main_d  = BUBBLE_ZERO ? '0 : main_q;
      skid_d  = BUBBLE_ZERO ? '0 : skid_q;
    end else begin
      case (state_q)
        EMPTY: begin
          state_d = acc ? ONE : EMPTY;
          main_d  = acc ? in_w : main_q;
        end
        ONE: begin
          state_d = (acc && !dlv) ? TWO : (!acc && dlv) ? EMPTY : ONE;
          main_d  = (acc && dlv) ? in_w : main_q;
          skid_d  = (acc && !dlv) ? in_w : skid_q;
        end
        TWO: begin
          state_d = dlv ? ONE : TWO;
          main_d  = dlv ? skid_q : main_q;
          skid_d  = dlv ? '0 : skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
  assign {ctrlOut, dataOut, tagOut} = (BUBBLE_ZERO && !validOut) ? '0 : main_q;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  always_comb begin
    stall_cnt_d  = (stallIn && !flushIn && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    bubble_cnt_d = (!validOut && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
  end
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign stallCntOut  = stall_cnt_q;
  assign bubbleCntOut = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid; an occupancy/queue model predicts every cycle.
module tb_pipe_stage_skid;
  localparam int CTRL_W = 12, DATA_W = 32, N_LANES = 4, TAG_W = 15;
  localparam int PW = CTRL_W + N_LANES*DATA_W + TAG_W;
  logic clkIn = 1'b0, resetIn = 1'b0, flushIn = 1'b0, stallIn = 1'b0, validIn = 1'b0, readyIn = 1'b0;
  logic readyOut, validOut;
  logic [CTRL_W-1:0] ctrlIn = '0, ctrlOut;
  logic [N_LANES*DATA_W-1:0] dataIn = '0, dataOut;
  logic [TAG_W-1:0] tagIn = '0, tagOut;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stallCntOut, bubbleCntOut;
`endif
  int n_cmp = 0, n_bad = 0;
  int stl = 0, bub = 0;
  logic [PW-1:0] sb[$];

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .N_LANES(N_LANES), .TAG_W(TAG_W), .BUBBLE_ZERO(1'b1)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .flushIn(flushIn), .stallIn(stallIn),
    .validIn(validIn), .readyOut(readyOut), .ctrlIn(ctrlIn), .dataIn(dataIn), .tagIn(tagIn),
    .validOut(validOut), .readyIn(readyIn),
`ifdef PIPE_STAGE_STATS_EN
    .stallCntOut(stallCntOut), .bubbleCntOut(bubbleCntOut),
`endif
    .ctrlOut(ctrlOut), .dataOut(dataOut), .tagOut(tagOut));

  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [CTRL_W-1:0] c);
    validIn = v;
    ctrlIn  = c;
    dataIn  = {$urandom, $urandom, $urandom, $urandom};
    tagIn   = TAG_W'($urandom);
  endtask

  // called just after a falling edge: check outputs against the model, then advance one cycle
  task automatic tick();
    int occ;
    logic acc, dlv;
    logic [PW-1:0] cur;
    occ = sb.size();
    check("readyOut", PW'(readyOut), PW'(occ < 2));
    check("validOut", PW'(validOut), PW'(occ > 0));
    check("payload", {ctrlOut, dataOut, tagOut}, occ > 0 ? sb[0] : '0);
    acc = validIn && occ < 2 && !stallIn && !flushIn;
    dlv = occ > 0 && readyIn && !stallIn && !flushIn;
    cur = {ctrlIn, dataIn, tagIn};
    if (stallIn && !flushIn && stl != 65535) stl++;
    if (occ == 0 && bub != 65535) bub++;
    @(posedge clkIn);
    if (flushIn) sb.delete();
    else begin
      if (dlv) void'(sb.pop_front());
      if (acc) sb.push_back(cur);
    end
    @(negedge clkIn);
  endtask

  initial begin
    repeat (2) @(negedge clkIn);
    check("reset_ready", PW'(readyOut), PW'(1));
    check("reset_valid", PW'(validOut), PW'(0));
    check("reset_payload", {ctrlOut, dataOut, tagOut}, '0);
    resetIn = 1'b1;
    tick();
    // streaming 1..8
    readyIn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, CTRL_W'(i));
      tick();
    end
    validIn = 1'b0;
    repeat (3) tick();
    // backpressure: A in main, B into skid, C refused
    set_in(1'b1, 12'h0A0);
    tick();
    readyIn = 1'b0;
    set_in(1'b1, 12'h0B0);
    tick();
    set_in(1'b1, 12'h0C0);
    repeat (2) tick();
    validIn = 1'b0;
    readyIn = 1'b1;
    repeat (3) tick();
    // flush from TWO drops held entries and the presented one
    readyIn = 1'b0;
    set_in(1'b1, 12'h0D0);
    tick();
    set_in(1'b1, 12'h0E0);
    tick();
    set_in(1'b1, 12'h0C1);
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    validIn = 1'b0;
    readyIn = 1'b1;
    repeat (2) tick();
    // stall with traffic on both sides
    set_in(1'b1, 12'h0F0);
    tick();
    set_in(1'b1, 12'h060);
    stallIn = 1'b1;
    repeat (3) tick();
    stallIn = 1'b0;
    tick();
    validIn = 1'b0;
    repeat (3) tick();
    // flush and stall together: flush wins
    readyIn = 1'b0;
    set_in(1'b1, 12'h080);
    tick();
    set_in(1'b1, 12'h081);
    stallIn = 1'b1;
    flushIn = 1'b1;
    tick();
    stallIn = 1'b0;
    flushIn = 1'b0;
    validIn = 1'b0;
    repeat (2) tick();
    // random traffic
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 1)), CTRL_W'($urandom));
      readyIn = 1'($urandom_range(0, 3) != 0);
      stallIn = 1'($urandom_range(0, 7) == 0);
      flushIn = 1'($urandom_range(0, 31) == 0);
      tick();
    end
    stallIn = 1'b0;
    flushIn = 1'b0;
    // async reset mid-cycle with TWO occupied
    readyIn = 1'b0;
    repeat (2) begin
      set_in(1'b1, CTRL_W'($urandom));
      tick();
    end
    validIn = 1'b0;
    check("two_before_reset", PW'(sb.size()), PW'(2));
    #2 resetIn = 1'b0;
    #1;
    check("areset_valid", PW'(validOut), PW'(0));
    check("areset_ready", PW'(readyOut), PW'(1));
    check("areset_payload", {ctrlOut, dataOut, tagOut}, '0);
    sb.delete();
    stl = 0;
    bub = 0;
    @(negedge clkIn);
    resetIn = 1'b1;
    tick();
`ifdef PIPE_STAGE_STATS_EN
    stl = 0;
    bub = 0;
    resetIn = 1'b0;
    @(negedge clkIn);
    resetIn = 1'b1;
    stallIn = 1'b1;
    repeat (5) tick();
    stallIn = 1'b0;
    repeat (4) tick();
    check("stall_cnt5", PW'(stallCntOut), PW'(5));
    check("bubble_cnt", PW'(bubbleCntOut), PW'(bub));
    stallIn = 1'b1;
    repeat (70000) tick();
    stallIn = 1'b0;
    tick();
    check("stall_cnt_sat", PW'(stallCntOut), PW'(16'hFFFF));
    check("bubble_cnt_sat", PW'(bubbleCntOut), PW'(bub));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
